ctrl_word_sequencer: RTL and testbench

CTRL_WORD_SEQUENCER -- requirements
Module: ctrl_word_sequencer

---
 rtl/lud_ctrl_pkg.sv | 29 ++
 rtl/ctrl_prefetch_buf.sv | 43 ++++
 rtl/ctrl_word_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ctrl_word_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lud_ctrl_pkg.sv
// Shared definitions for the LUD control-word sequencer: FSM states, instruction field offsets, idle control value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lud_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Instruction layout, LSB first: last flag, hold count, control word.
  localparam int LAST_BIT             = 0;
  localparam int REPEAT_LSB           = 1;
  localparam int DEFAULT_REPEAT_WIDTH = 8;

  // Control field offset for an arbitrary hold-count width.
  function automatic int ctrl_lsb(input int repeat_width);
    return REPEAT_LSB + repeat_width;
  endfunction

  // Control field offset for the default hold-count width.
  localparam int CTRL_LSB = REPEAT_LSB + DEFAULT_REPEAT_WIDTH;

  // Idle control word is all-zero: no BRAM writes, all selects 0.
  localparam logic CTRL_IDLE_BIT = 1'b0;

endpackage

// File: rtl/ctrl_prefetch_buf.sv
// One-entry next-word buffer with a bypass from the program memory read port.
// Latency: 0 cycles on bypass (in_dat straight to out_dat), 1 cycle when the word is parked.
// Backpressure: none internally; the caller only issues a read when nxt_vld_next says the slot is free.
module ctrl_prefetch_buf #(
  parameter int WORD_WIDTH = 69
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [WORD_WIDTH-1:0] in_dat,
  input  logic                  take,
  output logic [WORD_WIDTH-1:0] out_dat,
  output logic                  nxt_vld_next
);

  logic                  nxt_vld;
  logic [WORD_WIDTH-1:0] nxt_dat;
  logic                  bypass;
  logic                  wr;

  // Bypass when the consumer takes a word while the slot is empty; otherwise park arriving data.
  always_comb begin
    bypass       = take & ~nxt_vld;
    wr           = in_vld & ~bypass & ~flush;
    nxt_vld_next = ~flush & (wr | (nxt_vld & ~take));
    out_dat      = nxt_vld ? nxt_dat : in_dat;
  end

  // Slot storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_vld <= 1'b0;
      nxt_dat <= '0;
    end else begin
      nxt_vld <= nxt_vld_next;
      if (wr) begin
        nxt_dat <= in_dat;
      end
    end
  end

endmodule

// File: rtl/ctrl_word_sequencer.sv
// Plays a program of control words from program memory onto CTRL_Signal, each held repeat+1 cycles, back-to-back.
// Latency: start in cycle 0, first word on CTRL_Signal in cycle 2, done pulse the cycle after the last word.
// Backpressure: none; reads are issued only when the prefetch slot is free. Optional SEQ_CYCLE_CNT_EN adds cycle_count.
module ctrl_word_sequencer
  import lud_ctrl_pkg::*;
#(
  parameter int CTRL_WIDTH      = 60,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int REPEAT_WIDTH    = 8
) (
  input  logic                                CLK_100,
  input  logic                                RST,
  input  logic                                start,
  input  logic [PROG_ADDR_WIDTH-1:0]          start_addr,
  input  logic                                abort,
  output logic                                prog_en,
  output logic [PROG_ADDR_WIDTH-1:0]          prog_addr,
  input  logic [CTRL_WIDTH+REPEAT_WIDTH:0]    prog_dout,
`ifdef SEQ_CYCLE_CNT_EN
  output logic [31:0]                         cycle_count,
`endif
  output logic [CTRL_WIDTH-1:0]               CTRL_Signal,
  output logic                                busy,
  output logic                                done
);

  localparam int INSTR_W  = CTRL_WIDTH + REPEAT_WIDTH + 1;
  localparam int CTRL_OFS = ctrl_lsb(REPEAT_WIDTH);

  seq_state_t                 state, state_n;
  logic [PROG_ADDR_WIDTH-1:0] pc;
  logic [REPEAT_WIDTH-1:0]    hold_cnt;
  logic [CTRL_WIDTH-1:0]      cur_ctrl;
  logic                       cur_last;
  logic                       inflight;
  logic                       last_seen;

  logic                       accept;
  logic                       take;
  logic                       flush;
  logic                       issue;
  logic                       in_vld;
  logic                       last_seen_n;
  logic                       word_end;
  logic                       busy_c;
  logic                       done_c;
  logic [CTRL_WIDTH-1:0]      ctrl_c;
  logic [INSTR_W-1:0]         nxt_word;
  logic                       nxt_vld_next;

  ctrl_prefetch_buf #(
    .WORD_WIDTH (INSTR_W)
  ) u_prefetch (
    .clk          (CLK_100),
    .rst          (RST),
    .flush        (flush),
    .in_vld       (in_vld),
    .in_dat       (prog_dout),
    .take         (take),
    .out_dat      (nxt_word),
    .nxt_vld_next (nxt_vld_next)
  );

  // Next state, word hand-off and status; returning data is dropped once the last word has been captured.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    take        = 1'b0;
    flush       = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    ctrl_c      = {CTRL_WIDTH{CTRL_IDLE_BIT}};
    in_vld      = inflight & ~last_seen;
    last_seen_n = last_seen | (in_vld & prog_dout[LAST_BIT]);
    word_end    = (hold_cnt == '0);
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = PRIME;
        end
      end
      PRIME: begin
        busy_c = 1'b1;
        if (abort) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else begin
          take    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        ctrl_c = cur_ctrl;
        if (abort) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else if (word_end) begin
          if (cur_last) begin
            flush   = 1'b1;
            state_n = DONE;
          end else begin
            take = 1'b1;
          end
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Prefetch read: only while running, before the last word is seen, and when the slot will be free on return.
  always_comb begin
    issue = 1'b0;
    if ((state == PRIME || state == RUN) && !abort && !RST &&
        state_n != DONE && !last_seen_n && !nxt_vld_next) begin
      issue = 1'b1;
    end
  end

  // Outputs are forced quiet while reset is asserted, even if start is high.
  always_comb begin
    prog_en     = ~RST & (accept | issue);
    prog_addr   = '0;
    if (!RST && accept) begin
      prog_addr = start_addr;
    end else if (!RST && issue) begin
      prog_addr = pc;
    end
    CTRL_Signal = RST ? {CTRL_WIDTH{CTRL_IDLE_BIT}} : ctrl_c;
    busy        = ~RST & busy_c;
    done        = ~RST & done_c;
  end

  // FSM state, program counter, current word and hold counter.
  always_ff @(posedge CLK_100) begin
    if (RST) begin
      state     <= IDLE;
      pc        <= '0;
      hold_cnt  <= '0;
      cur_ctrl  <= '0;
      cur_last  <= 1'b0;
      inflight  <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      state    <= state_n;
      inflight <= accept | issue;
      if (accept) begin
        pc        <= start_addr + 1'b1;
        last_seen <= 1'b0;
      end else begin
        last_seen <= last_seen_n;
        if (issue) begin
          pc <= pc + 1'b1;
        end
      end
      if (take) begin
        cur_ctrl <= nxt_word[CTRL_OFS +: CTRL_WIDTH];
        hold_cnt <= nxt_word[REPEAT_LSB +: REPEAT_WIDTH];
        cur_last <= nxt_word[LAST_BIT];
      end else if (state == RUN && !word_end) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

`ifdef SEQ_CYCLE_CNT_EN
  // Busy-cycle counter: cleared on an accepted start, saturating, held after done or abort.
  always_ff @(posedge CLK_100) begin
    if (RST) begin
      cycle_count <= '0;
    end else if (accept) begin
      cycle_count <= '0;
    end else if (busy_c && cycle_count != 32'hFFFF_FFFF) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Directed bench for ctrl_word_sequencer with a registered program memory model.
// Latency: memory returns data the cycle after prog_en.
// Backpressure: n/a. Define SEQ_CYCLE_CNT_EN to also check cycle_count.
module tb_ctrl_word_sequencer;
  import lud_ctrl_pkg::*;

  localparam int CW = 60;
  localparam int AW = 10;
  localparam int RW = 8;
  localparam int IW = CW + RW + 1;

  logic          CLK_100 = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          abort = 1'b0;
  logic          prog_en;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_dout = '0;
  logic [CW-1:0] CTRL_Signal;
  logic          busy;
  logic          done;
`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0]   cycle_count;
`endif

  logic [IW-1:0] mem [1024];

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] cap_ctrl [32];
  logic        cap_busy [32];
  logic        cap_done [32];
  logic        cap_en   [32];
  logic [AW-1:0] cap_addr [32];
  logic [31:0] cap_cnt  [32];

  logic [63:0] exp_ctrl [32];
  logic        exp_busy [32];
  logic        exp_done [32];
  logic        exp_en   [32];
  logic [AW-1:0] exp_addr [32];

  localparam logic [CW-1:0] A = 60'hA00_0000_0000_0001;
  localparam logic [CW-1:0] B = 60'hB00_0000_0000_0002;
  localparam logic [CW-1:0] C = 60'hC00_0000_0000_0003;
  localparam logic [CW-1:0] D = 60'hD00_0000_0000_0004;
  localparam logic [CW-1:0] E = 60'hE00_0000_0000_0005;

  ctrl_word_sequencer #(
    .CTRL_WIDTH      (CW),
    .PROG_ADDR_WIDTH (AW),
    .REPEAT_WIDTH    (RW)
  ) dut (
    .CLK_100     (CLK_100),
    .RST         (RST),
    .start       (start),
    .start_addr  (start_addr),
    .abort       (abort),
    .prog_en     (prog_en),
    .prog_addr   (prog_addr),
    .prog_dout   (prog_dout),
`ifdef SEQ_CYCLE_CNT_EN
    .cycle_count (cycle_count),
`endif
    .CTRL_Signal (CTRL_Signal),
    .busy        (busy),
    .done        (done)
  );

  always #5 CLK_100 = ~CLK_100;

  // Registered program memory read port.
  always @(posedge CLK_100) begin
    if (prog_en) prog_dout <= mem[prog_addr];
  end

  function automatic logic [IW-1:0] mk(input logic [CW-1:0] c, input logic [RW-1:0] r, input logic l);
    logic [IW-1:0] w;
    w = '0;
    w[CTRL_LSB +: CW] = c;
    w[REPEAT_LSB +: RW] = r;
    w[LAST_BIT] = l;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_seq(input int addr, input int n, input logic [31:0] sm,
                         input logic [31:0] am, input logic [31:0] rm);
    for (int k = 0; k < n; k++) begin
      start      = sm[k];
      abort      = am[k];
      RST        = rm[k];
      start_addr = addr[AW-1:0];
      @(negedge CLK_100);
      cap_ctrl[k] = {4'h0, CTRL_Signal};
      cap_busy[k] = busy;
      cap_done[k] = done;
      cap_en[k]   = prog_en;
      cap_addr[k] = prog_addr;
`ifdef SEQ_CYCLE_CNT_EN
      cap_cnt[k]  = cycle_count;
`else
      cap_cnt[k]  = '0;
`endif
      @(posedge CLK_100);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    RST   = 1'b0;
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 32; k++) begin
      exp_ctrl[k] = '0;
      exp_busy[k] = 1'b0;
      exp_done[k] = 1'b0;
      exp_en[k]   = 1'b0;
      exp_addr[k] = '0;
    end
  endtask

  task automatic compare_trace(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s ctrl c%0d", tag, k), cap_ctrl[k], exp_ctrl[k]);
      chk($sformatf("%s busy c%0d", tag, k), 64'(cap_busy[k]), 64'(exp_busy[k]));
      chk($sformatf("%s done c%0d", tag, k), 64'(cap_done[k]), 64'(exp_done[k]));
      chk($sformatf("%s prog_en c%0d", tag, k), 64'(cap_en[k]), 64'(exp_en[k]));
      if (exp_en[k]) chk($sformatf("%s prog_addr c%0d", tag, k), 64'(cap_addr[k]), 64'(exp_addr[k]));
    end
  endtask

  // Basic program at 5: A(r0), B(r2), C(r0,last).
  task automatic set_exp_basic();
    clear_exp();
    exp_ctrl[2] = 64'(A); exp_ctrl[3] = 64'(B); exp_ctrl[4] = 64'(B);
    exp_ctrl[5] = 64'(B); exp_ctrl[6] = 64'(C);
    for (int k = 1; k <= 6; k++) exp_busy[k] = 1'b1;
    exp_done[7] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_en[k]   = 1'b1;
      exp_addr[k] = AW'(5 + k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = mk(A, 8'd0, 1'b0);
    mem[6] = mk(B, 8'd2, 1'b0);
    mem[7] = mk(C, 8'd0, 1'b1);
    for (int i = 0; i < 8; i++) mem[100 + i] = mk(60'h100 + 60'(i), 8'd0, i == 7);
    mem[1022] = mk(60'h3FE, 8'd1, 1'b0);
    mem[1023] = mk(60'h3FF, 8'd0, 1'b0);
    mem[0]    = mk(60'h400, 8'd0, 1'b1);
    mem[200]  = mk(D, 8'd3, 1'b0);
    mem[201]  = mk(E, 8'd0, 1'b1);

    // Reset with start held high: everything quiet.
    RST = 1'b1;
    start = 1'b1;
    start_addr = 10'd5;
    repeat (2) @(posedge CLK_100);
    @(negedge CLK_100);
    chk("rst ctrl", {4'h0, CTRL_Signal}, 64'h0);
    chk("rst busy", 64'(busy), 64'h0);
    chk("rst done", 64'(done), 64'h0);
    chk("rst prog_en", 64'(prog_en), 64'h0);
    chk("rst prog_addr", 64'(prog_addr), 64'h0);
`ifdef SEQ_CYCLE_CNT_EN
    chk("rst cycle_count", 64'(cycle_count), 64'h0);
`endif
    @(posedge CLK_100);
    #1;
    RST = 1'b0;
    start = 1'b0;
    @(posedge CLK_100);
    #1;

    // Basic program; extra starts in RUN (c4) and DONE (c7) are ignored.
    set_exp_basic();
    run_seq(5, 10, 32'h091, 32'h0, 32'h0);
    compare_trace("basic", 10);
`ifdef SEQ_CYCLE_CNT_EN
    chk("basic cycle_count held", 64'(cap_cnt[9]), 64'd6);
`endif

    // Eight repeat-0 words back-to-back; abort with start in IDLE loses to start.
    clear_exp();
    for (int k = 0; k < 8; k++) begin
      exp_ctrl[k + 2] = 64'h100 + 64'(k);
      exp_en[k]       = 1'b1;
      exp_addr[k]     = AW'(100 + k);
    end
    for (int k = 1; k <= 9; k++) exp_busy[k] = 1'b1;
    exp_done[10] = 1'b1;
    run_seq(100, 12, 32'h1, 32'h1, 32'h0);
    compare_trace("burst8", 12);

    // Address wrap: reads 1022, 1023, 0.
    clear_exp();
    exp_ctrl[2] = 64'h3FE; exp_ctrl[3] = 64'h3FE; exp_ctrl[4] = 64'h3FF; exp_ctrl[5] = 64'h400;
    for (int k = 1; k <= 5; k++) exp_busy[k] = 1'b1;
    exp_done[6] = 1'b1;
    exp_en[0] = 1'b1; exp_addr[0] = 10'd1022;
    exp_en[1] = 1'b1; exp_addr[1] = 10'd1023;
    exp_en[3] = 1'b1; exp_addr[3] = 10'd0;
    run_seq(1022, 8, 32'h1, 32'h0, 32'h0);
    compare_trace("wrap", 8);

    // Abort in the 2nd cycle of a repeat-3 word; later aborts in IDLE do nothing.
    clear_exp();
    exp_ctrl[2] = 64'(D); exp_ctrl[3] = 64'(D);
    exp_busy[1] = 1'b1; exp_busy[2] = 1'b1; exp_busy[3] = 1'b1;
    exp_en[0] = 1'b1; exp_addr[0] = 10'd200;
    exp_en[1] = 1'b1; exp_addr[1] = 10'd201;
    run_seq(200, 9, 32'h1, 32'h068, 32'h0);
    compare_trace("abort", 9);
`ifdef SEQ_CYCLE_CNT_EN
    chk("abort cycle_count held", 64'(cap_cnt[8]), 64'd3);
`endif

    // Normal run after the abort.
    set_exp_basic();
    run_seq(5, 10, 32'h1, 32'h0, 32'h0);
    compare_trace("after_abort", 10);
`ifdef SEQ_CYCLE_CNT_EN
    chk("restart cycle_count cleared", 64'(cap_cnt[1]), 64'd0);
    chk("restart cycle_count final", 64'(cap_cnt[9]), 64'd6);
`endif

    // Reset in RUN together with start: reset wins, FSM stays idle.
    clear_exp();
    exp_ctrl[2] = 64'(A);
    exp_busy[1] = 1'b1; exp_busy[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_en[k]   = 1'b1;
      exp_addr[k] = AW'(5 + k);
    end
    run_seq(5, 7, 32'h9, 32'h0, 32'h8);
    compare_trace("rst_run", 7);
    chk("rst_run prog_addr under reset", 64'(cap_addr[3]), 64'h0);
`ifdef SEQ_CYCLE_CNT_EN
    chk("rst_run cycle_count", 64'(cap_cnt[4]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
